sevenseg_scan_ctrl: RTL and testbench

//  Upstream driver for the per-digit hex/BCD seven-segment decoder. Converts a binary value
//  to BCD with a sequential double-dabble, one bit per clock, and holds the result in a display register.

---
 rtl/sevenseg_scan_ctrl_if.sv | 24 ++
 rtl/sevenseg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_ctrl_if.sv
// Bus between the seven-segment scan controller and its user: value/strobe in,
// status and decoder/anode drive out.
interface sevenseg_scan_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
);
    logic [WIDTH-1:0]  bin_in;
    logic              load;
    logic              blank_lz;
    logic              busy;
    logic              ovf;
    logic [3:0]        digit;
    logic [DIGITS-1:0] an;

    modport master (
        output bin_in, load, blank_lz,
        input  busy, ovf, digit, an
    );

    modport slave (
        input  bin_in, load, blank_lz,
        output busy, ovf, digit, an
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Seven-segment scan controller: sequential double-dabble binary->BCD into a
// display register, scanned across DIGITS common-anode digits.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for load; display register shows last committed value
// CONV  | one double-dabble step per cycle, WIDTH cycles, then commit
//
// The interface instance must carry the same DIGITS/WIDTH as this module.
module sevenseg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    sevenseg_scan_ctrl_if.slave  bus
);
    localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW    = $clog2(WIDTH + 1);
    localparam int NW    = 4 * DIGITS;

    function automatic logic [63:0] pow10_m1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0]   MAXVAL = pow10_m1(DIGITS);
    localparam logic [NW-1:0] NINES  = {DIGITS{4'h9}};

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q;
    logic [NW-1:0]     scratch_q;
    logic [BW-1:0]     bitcnt_q;
    logic              ovf_pend_q;
    logic [NW-1:0]     display_q;
    logic              ovf_q;
    logic [SEL_W-1:0]  sel_q;
    logic [PRE_W-1:0]  presc_q;

    logic [NW-1:0]       adj;
    logic [NW+WIDTH-1:0] step;
    logic                last_step;
    logic                upper_zero;
    logic [3:0]          cur_nib;

    assign last_step = (bitcnt_q == BW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: start on load when idle, finish when the bit counter runs out
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.load) state_d = CONV;
            CONV: if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One double-dabble step: +3 on every nibble >= 5, then shift left by one
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        step = {adj, shift_q} << 1;
    end

    // Conversion datapath; display and ovf only change on the commit edge
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            scratch_q  <= '0;
            bitcnt_q   <= '0;
            ovf_pend_q <= 1'b0;
            display_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        shift_q    <= bus.bin_in;
                        scratch_q  <= '0;
                        bitcnt_q   <= BW'(WIDTH);
                        ovf_pend_q <= (64'(bus.bin_in) > MAXVAL);
                    end
                end
                CONV: begin
                    {scratch_q, shift_q} <= step;
                    bitcnt_q             <= bitcnt_q - BW'(1);
                    if (last_step) begin
                        display_q <= ovf_pend_q ? NINES : step[NW+WIDTH-1 -: NW];
                        ovf_q     <= ovf_pend_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running scan: prescaler wraps at REFRESH_DIV-1 and advances the digit select
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            sel_q   <= '0;
        end else if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
            presc_q <= '0;
            sel_q   <= (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    // Digit mux with leading-zero blanking; digit 0 is never blanked
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(sel_q) && display_q[4*i +: 4] != 4'h0) upper_zero = 1'b0;
        end
        cur_nib = display_q[int'(sel_q)*4 +: 4];
        bus.digit = (bus.blank_lz && sel_q != '0 && upper_zero) ? 4'hF : cur_nib;
    end

    assign bus.an   = ~(DIGITS'(1) << sel_q);
    assign bus.busy = (state_q == CONV);
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
module tb_sevenseg_scan_ctrl;
    localparam int DIGITS      = 4;
    localparam int WIDTH       = 14;
    localparam int REFRESH_DIV = 4;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] q_dig[$];
    logic       q_ovf[$];
    logic [3:0] last_exp[4];
    logic [3:0] prev[4];

    sevenseg_scan_ctrl_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus();

    sevenseg_scan_ctrl #(
        .DIGITS(DIGITS), .WIDTH(WIDTH), .REFRESH_DIV(REFRESH_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: decimal digits, saturation to 9s, leading-zero blanking
    task automatic push_expect(input int v, input logic blank);
        logic [3:0] d[4];
        logic       ov;
        int         p;
        logic       z;
        ov = (v > 9999);
        p  = 1;
        for (int i = 0; i < 4; i++) begin
            d[i] = ov ? 4'd9 : 4'((v / p) % 10);
            p    = p * 10;
        end
        for (int s = 1; s < 4; s++) begin
            z = 1'b1;
            for (int k = s; k < 4; k++) if (d[k] != 4'd0) z = 1'b0;
            if (blank && z && !ov) d[s] = 4'hF;
        end
        for (int i = 0; i < 4; i++) begin
            q_dig.push_back(d[i]);
            last_exp[i] = d[i];
        end
        q_ovf.push_back(ov);
    endtask

    function automatic int sel_of(input logic [3:0] an);
        int s;
        s = -1;
        for (int i = 0; i < 4; i++) if (an[i] == 1'b0) s = i;
        return s;
    endfunction

    // Pop one expected digit per slot as the scan reaches it
    task automatic check_scan(input string tag);
        int         t;
        logic [3:0] want;
        logic [3:0] want_an;
        for (int s = 0; s < 4; s++) begin
            want_an = ~(4'b0001 << s);
            t = 0;
            while (bus.an !== want_an && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (t >= 40) check({tag, "_an_timeout"}, 32'(bus.an), 32'(want_an));
            want = (q_dig.size() > 0) ? q_dig.pop_front() : 4'hX;
            check($sformatf("%s_d%0d", tag, s), 32'(bus.digit), 32'(want));
        end
    endtask

    task automatic check_ovf(input string tag);
        logic want;
        want = (q_ovf.size() > 0) ? q_ovf.pop_front() : 1'bX;
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(want));
    endtask

    task automatic do_load(input string tag, input int v, input logic blank);
        int cnt;
        bus.blank_lz = blank;
        bus.bin_in   = WIDTH'(v);
        bus.load     = 1'b1;
        push_expect(v, blank);
        @(negedge clk);
        bus.load = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 32'(cnt), 32'(WIDTH));
        check_ovf(tag);
        check_scan(tag);
    endtask

    initial begin
        int cnt;
        int s;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.bin_in   = '0;
        bus.blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_an",    32'(bus.an),    32'(4'b1110));
        check("rst_digit", 32'(bus.digit), 32'(4'h0));
        check("rst_busy",  32'(bus.busy),  32'(1'b0));
        check("rst_ovf",   32'(bus.ovf),   32'(1'b0));
        repeat (4) @(negedge clk);
        check("scan_1", 32'(bus.an), 32'(4'b1101));
        repeat (4) @(negedge clk);
        check("scan_2", 32'(bus.an), 32'(4'b1011));
        repeat (4) @(negedge clk);
        check("scan_3", 32'(bus.an), 32'(4'b0111));
        repeat (4) @(negedge clk);
        check("scan_wrap", 32'(bus.an), 32'(4'b1110));

        do_load("v1234",  1234,  1'b0);
        do_load("lz7",    7,     1'b1);
        do_load("lz0",    0,     1'b1);
        do_load("lz1002", 1002,  1'b1);
        do_load("nolz7",  7,     1'b0);
        do_load("ovf",    12000, 1'b0);
        do_load("clr5",   5,     1'b0);

        // load ignored while busy; old display held until commit
        prev = last_exp;
        bus.blank_lz = 1'b0;
        bus.bin_in   = WIDTH'(1234);
        bus.load     = 1'b1;
        push_expect(1234, 1'b0);
        @(negedge clk);
        bus.load = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            s = sel_of(bus.an);
            check("hold_digit", 32'(bus.digit), (s >= 0) ? 32'(prev[s]) : 32'hDEAD);
            check("hold_ovf", 32'(bus.ovf), 32'(1'b0));
            bus.load = (cnt == 4);
            if (cnt == 4) bus.bin_in = WIDTH'(42);
            cnt++;
            @(negedge clk);
        end
        bus.load = 1'b0;
        check("ign_busy_len", 32'(cnt), 32'(WIDTH));
        repeat (2) @(negedge clk);
        check("ign_no_queue", 32'(bus.busy), 32'(1'b0));
        check_ovf("ign");
        check_scan("ign");

        // reset during CONV cycle 7
        bus.bin_in = WIDTH'(9876);
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_busy_pre", 32'(bus.busy), 32'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy",  32'(bus.busy),  32'(1'b0));
        check("mid_an",    32'(bus.an),    32'(4'b1110));
        check("mid_digit", 32'(bus.digit), 32'(4'h0));
        rst = 1'b0;
        push_expect(0, 1'b0);
        check_ovf("mid");
        check_scan("mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
